lcd_line_scheduler: RTL
=======================

// Module: lcd_line_scheduler
// PURPOSE
//  Shares the character-LCD driver between two line clients (0 = top line, 1 = bottom line).
//  Round-robin arbitration picks one pending line refresh.
//  For the granted line it issues a Set-DDRAM-Address command, then LINE_LEN characters read from
//  that client's buffer, each through the driver's data_ready/busy_flag handshake.
//  Sits between the line-buffer producers (e.g. the energy readout) and the LCD driver; it replaces
//  the single-ROM demo controller.
// PARAMETERS
//  LINE_LEN        16     characters per refresh (1..16); rd_addr counts 0..LINE_LEN-1
//  ACCEPT_TIMEOUT  1000   clocks to wait for lcd_busy to rise after a data_ready pulse before re-issuing
// PORTS
//  clock           in   1  system clock (100 MHz), all logic on posedge
//  reset_n         in   1  asynchronous, active-low reset
//  req             in   2  level request per client: line buffer has new content
//  done            out  2  one-clock pulse to served client when its line is fully written
//  rd_sel          out  1  client whose buffer is being read (= current grant)
//  rd_addr         out  4  character index into selected buffer
//  rd_data         in   8  ASCII char from selected buffer; combinational, valid same cycle as rd_addr
//  lcd_data        out  9  {rs, d[7:0]} word to LCD driver d_in
//  lcd_data_ready  out  1  one-clock pulse: lcd_data valid, start a write
//  lcd_busy        in   1  driver busy_flag: high during power-on init and during each write
//  active          out  1  high from grant until done pulse
//  timeout_err     out  1  sticky: an ACCEPT_TIMEOUT expiry occurred; cleared only by reset
// BEHAVIOUR
//  Reset values (async, reset_n=0): all outputs 0, state IDLE, rr pointer = client 0 preferred,
//   counters 0. Reset mid-transfer abandons the line with no done pulse.
//  FSM: IDLE -> LOAD -> WAIT_FREE -> PULSE -> WAIT_ACCEPT -> WAIT_DONE -> (LOAD | FINISH) -> IDLE.
//  IDLE: if req!=0, grant the single requester. If both request, grant !last_served.
//   Latch grant into rd_sel, set char_idx=0, phase=CMD, active=1, go to LOAD.
//  LOAD: phase CMD -> lcd_data = {1'b0, 8'h80 | LINE_BASE[grant]} (0x80 or 0xC0).
//   Phase CHAR -> lcd_data = {1'b1, rd_data}, with rd_addr = char_idx.
//   lcd_data is registered here and held unchanged until WAIT_DONE exits.
//  WAIT_FREE: stay while lcd_busy=1; this covers the driver's ~100 ms init, so no word is lost.
//  PULSE: lcd_data_ready=1 for exactly one clock; clear the timeout counter.
//  WAIT_ACCEPT: wait for lcd_busy=1 (driver latched word).
//   If the counter reaches ACCEPT_TIMEOUT, set timeout_err and return to PULSE with the same word.
//  WAIT_DONE: wait for lcd_busy=0 (driver honours 2 ms cmd / 40 us char internally).
//   After CMD: phase=CHAR -> LOAD.
//   After CHAR: if char_idx==LINE_LEN-1 -> FINISH, else char_idx+1 -> LOAD.
//  FINISH: done[grant]=1 for one clock, last_served=grant, active=0 -> IDLE.
//  req is sampled only in IDLE. Deasserting req mid-line does not abort the line.
//   A req still high at FINISH is re-served after the other client (round-robin).
//  Per line: exactly 1 command + LINE_LEN char writes = LINE_LEN+1 data_ready pulses (no timeouts).
//  Min latency req->first data_ready: 3 clocks (IDLE, LOAD, WAIT_FREE with busy=0).
//  char_idx is 4 bits; no wrap past LINE_LEN-1. LINE_LEN=16 ends at 15 without overflow.
//  lcd_busy already low in WAIT_ACCEPT, or already high in WAIT_FREE, simply holds state.
//   The block never issues data_ready while lcd_busy=1.
// STRUCTURE
//  Shared include lcd_defs.vh: LCD_CMD_DDRAM=8'h80, LINE_BASE0=7'h00, LINE_BASE1=7'h40,
//   RS_CMD=1'b0, RS_CHAR=1'b1, FSM state encodings (also used by the LCD driver bench).
//  Sub-module rr_arbiter_2: req[1:0], last_served, enable -> grant_valid, grant (combinational).
//  Remainder is one registered FSM with char_idx, timeout counter, last_served.
// TESTING
//  1 Init hold: lcd_busy=1 for 5000 clks, req=2'b01 -> no data_ready until busy falls.
//    Then first word 9'h080.
//  2 Single line: req=2'b01, driver model raises busy 1 clk after data_ready and holds 20 clks ->
//    17 pulses: 9'h080, then 9'h100|buf0[i] for i=0..15; done=2'b01 once; active low after.
//  3 Contention: req=2'b11 from reset -> client 0 line (cmd 0x080) fully, then client 1 (cmd 0x0C0).
//    done order 01 then 10. Repeat with last_served=0 -> client 1 first.
//  4 Timeout: driver ignores first pulse (busy stays 0) -> after ACCEPT_TIMEOUT clks same word re-pulsed.
//    timeout_err=1 and stays 1.
//  5 Reset mid-line: assert reset_n=0 after char 7 accepted.
//    Outputs 0 immediately, no done; after release + req=2'b10 line restarts with 9'h0C0.
//  6 req drop: req[0] falls after command accepted -> line still completes with 16 chars and done[0].

Source files
------------

// File: rtl/lcd_line_scheduler_pkg.sv
// rtl/lcd_line_scheduler_pkg.sv - shared LCD command constants and scheduler state types
// Purpose: constants for the HD44780-style command words, the scheduler FSM
// state and phase encodings, and a helper that builds the Set-DDRAM-Address word.
// Ports: none (package).
package lcd_line_scheduler_pkg;

    localparam logic [7:0] LCD_CMD_DDRAM = 8'h80;
    localparam logic [6:0] LINE_BASE0    = 7'h00;
    localparam logic [6:0] LINE_BASE1    = 7'h40;
    localparam logic       RS_CMD        = 1'b0;
    localparam logic       RS_CHAR       = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_LOAD        = 3'd1,
        ST_WAIT_FREE   = 3'd2,
        ST_PULSE       = 3'd3,
        ST_WAIT_ACCEPT = 3'd4,
        ST_WAIT_DONE   = 3'd5,
        ST_FINISH      = 3'd6
    } state_t;

    typedef enum logic {
        PH_CMD  = 1'b0,
        PH_CHAR = 1'b1
    } phase_t;

    // Set-DDRAM-Address word for a display line: 0x080 for line 0, 0x0C0 for line 1.
    function automatic logic [8:0] ddram_cmd_word(input logic line);
        logic [6:0] base;
        base = line ? LINE_BASE1 : LINE_BASE0;
        return {RS_CMD, LCD_CMD_DDRAM | {1'b0, base}};
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// rtl/rr_arbiter_2.sv - two-client round-robin arbiter, combinational
// Purpose: picks one of two requesters; on contention the client that was not
// served last wins.
// Ports:
//   i_req[1:0]     level requests
//   i_last_served  client granted on the previous completed line
//   i_enable       arbitration allowed this cycle
//   o_grant_valid  a grant is being made
//   o_grant        granted client index
module rr_arbiter_2 (
    input  logic [1:0] i_req,
    input  logic       i_last_served,
    input  logic       i_enable,
    output logic       o_grant_valid,
    output logic       o_grant
);

    always_comb begin
        o_grant_valid = i_enable && (i_req != 2'b00);
        if (i_req == 2'b11) begin
            o_grant = ~i_last_served;
        end else begin
            o_grant = i_req[1];
        end
    end

endmodule

// File: rtl/lcd_line_scheduler.sv
// rtl/lcd_line_scheduler.sv - shares one character-LCD driver between two line clients
// Purpose: round-robin picks a pending line, then writes a Set-DDRAM-Address
// command followed by LINE_LEN characters from that client's buffer, each word
// going through the driver's data_ready / busy handshake.
// Ports:
//   i_clock, i_reset_n        clock, asynchronous active-low reset
//   i_req[1:0]                per-client refresh request (level)
//   o_done[1:0]               one-clock pulse to the client whose line finished
//   o_rd_sel, o_rd_addr[3:0]  buffer select and character index
//   i_rd_data[7:0]            character from the selected buffer (same cycle)
//   o_lcd_data[8:0]           {rs, d[7:0]} to the driver
//   o_lcd_data_ready          one-clock write strobe
//   i_lcd_busy                driver busy flag
//   o_active                  a line is being served
//   o_timeout_err             sticky: driver failed to accept a word in time
module lcd_line_scheduler
    import lcd_line_scheduler_pkg::*;
#(
    parameter int LINE_LEN       = 16,
    parameter int ACCEPT_TIMEOUT = 1000
) (
    input  logic       i_clock,
    input  logic       i_reset_n,
    input  logic [1:0] i_req,
    output logic [1:0] o_done,
    output logic       o_rd_sel,
    output logic [3:0] o_rd_addr,
    input  logic [7:0] i_rd_data,
    output logic [8:0] o_lcd_data,
    output logic       o_lcd_data_ready,
    input  logic       i_lcd_busy,
    output logic       o_active,
    output logic       o_timeout_err
);

    localparam int               CNT_W    = $clog2(ACCEPT_TIMEOUT + 1);
    localparam logic [3:0]       LAST_IDX = 4'(LINE_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCEPT_TIMEOUT - 1);

    state_t           r_state, w_state_nxt;
    phase_t           r_phase, w_phase_nxt;
    logic             r_sel, w_sel_nxt;
    logic [3:0]       r_char_idx, w_char_idx_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_last_served, w_last_served_nxt;
    logic [8:0]       r_lcd_data, w_lcd_data_nxt;
    logic             r_timeout_err, w_timeout_err_nxt;

    logic w_arb_en;
    logic w_grant_valid;
    logic w_grant;

    assign w_arb_en = (r_state == ST_IDLE);

    rr_arbiter_2 u_arb (
        .i_req         (i_req),
        .i_last_served (r_last_served),
        .i_enable      (w_arb_en),
        .o_grant_valid (w_grant_valid),
        .o_grant       (w_grant)
    );

    // last_served resets to client 1 so client 0 wins the first contention.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state       <= ST_IDLE;
            r_phase       <= PH_CMD;
            r_sel         <= 1'b0;
            r_char_idx    <= 4'd0;
            r_cnt         <= '0;
            r_last_served <= 1'b1;
            r_lcd_data    <= 9'd0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_phase       <= w_phase_nxt;
            r_sel         <= w_sel_nxt;
            r_char_idx    <= w_char_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_last_served <= w_last_served_nxt;
            r_lcd_data    <= w_lcd_data_nxt;
            r_timeout_err <= w_timeout_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_phase_nxt       = r_phase;
        w_sel_nxt         = r_sel;
        w_char_idx_nxt    = r_char_idx;
        w_cnt_nxt         = r_cnt;
        w_last_served_nxt = r_last_served;
        w_lcd_data_nxt    = r_lcd_data;
        w_timeout_err_nxt = r_timeout_err;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_valid) begin
                    w_sel_nxt      = w_grant;
                    w_char_idx_nxt = 4'd0;
                    w_phase_nxt    = PH_CMD;
                    w_state_nxt    = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // The word is captured once here and held through the whole
                // handshake, including any timeout re-issue.
                if (r_phase == PH_CMD) begin
                    w_lcd_data_nxt = ddram_cmd_word(r_sel);
                end else begin
                    w_lcd_data_nxt = {RS_CHAR, i_rd_data};
                end
                w_state_nxt = ST_WAIT_FREE;
            end
            ST_WAIT_FREE: begin
                if (!i_lcd_busy) begin
                    w_state_nxt = ST_PULSE;
                end
            end
            ST_PULSE: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT_ACCEPT;
            end
            ST_WAIT_ACCEPT: begin
                if (i_lcd_busy) begin
                    w_state_nxt = ST_WAIT_DONE;
                end else if (r_cnt == CNT_LAST) begin
                    w_timeout_err_nxt = 1'b1;
                    w_state_nxt       = ST_PULSE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT_DONE: begin
                if (!i_lcd_busy) begin
                    if (r_phase == PH_CMD) begin
                        w_phase_nxt = PH_CHAR;
                        w_state_nxt = ST_LOAD;
                    end else if (r_char_idx == LAST_IDX) begin
                        w_state_nxt = ST_FINISH;
                    end else begin
                        w_char_idx_nxt = r_char_idx + 4'd1;
                        w_state_nxt    = ST_LOAD;
                    end
                end
            end
            ST_FINISH: begin
                w_last_served_nxt = r_sel;
                w_state_nxt       = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign o_done           = (r_state == ST_FINISH) ? (r_sel ? 2'b10 : 2'b01) : 2'b00;
    assign o_lcd_data_ready = (r_state == ST_PULSE);
    assign o_active         = (r_state != ST_IDLE);
    assign o_rd_sel         = r_sel;
    assign o_rd_addr        = r_char_idx;
    assign o_lcd_data       = r_lcd_data;
    assign o_timeout_err    = r_timeout_err;

endmodule
